// File: rtl/switch_debounce_if.sv
// Switch conditioner signal bundle: raw pin toward the debouncer, clean level and strobes back.
// The o_glitch_cnt member exists only when SWITCH_DEBOUNCE_GLITCH_CNT_EN is defined.
interface switch_debounce_if #(
  parameter int GLITCH_WIDTH = 8
);
  logic i_sw;
  logic o_sw;
  logic o_rise;
  logic o_fall;
  logic o_busy;
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_WIDTH-1:0] o_glitch_cnt;

  modport master (output i_sw, input o_sw, input o_rise, input o_fall, input o_busy, input o_glitch_cnt);
  modport slave  (input i_sw, output o_sw, output o_rise, output o_fall, output o_busy, output o_glitch_cnt);
`else
  modport master (output i_sw, input o_sw, input o_rise, input o_fall, input o_busy);
  modport slave  (input i_sw, output o_sw, output o_rise, output o_fall, output o_busy);
`endif
endinterface

// File: rtl/switch_debounce.sv
// Synchronises a bouncing switch pin and qualifies each change over DEBOUNCE_CYCLES stable cycles.
// Optional rejected-bounce counter enabled by SWITCH_DEBOUNCE_GLITCH_CNT_EN.
module switch_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int GLITCH_WIDTH    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  switch_debounce_if.slave  bus
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [CNT_WIDTH-1:0]   cnt_s;
  logic                   reject_s;
  logic                   level_s;
  logic                   busy_s;
  logic                   sw_r;
  logic                   rise_r;
  logic                   fall_r;
  logic                   busy_r;

  // Synchroniser chain; only its last flop is visible to the FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.i_sw};
    end
  end

  assign s = sync_r[SYNC_STAGES-1];

  // FSM state and stability counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= LOW;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state: any reversal during a check abandons it, otherwise count to the limit.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    reject_s = 1'b0;
    case (state_r)
      LOW: begin
        if (s) begin
          state_s = CHK_HI;
          cnt_s   = '0;
        end else begin
          state_s = LOW;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_s  = LOW;
          reject_s = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          state_s = HIGH;
        end else begin
          cnt_s = cnt_r + CNT_WIDTH'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_s = CHK_LO;
          cnt_s   = '0;
        end else begin
          state_s = HIGH;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_s  = HIGH;
          reject_s = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          state_s = LOW;
        end else begin
          cnt_s = cnt_r + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_s = LOW;
        cnt_s   = '0;
      end
    endcase
  end

  // The accepted level is high in HIGH and while a fall is still being qualified.
  assign level_s = (state_r == HIGH) || (state_r == CHK_LO);
  assign busy_s  = (state_r == CHK_HI) || (state_r == CHK_LO);

  // Registered outputs; strobes come from comparing the new level with the held one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_r   <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      sw_r   <= level_s;
      rise_r <= level_s & ~sw_r;
      fall_r <= ~level_s & sw_r;
      busy_r <= busy_s;
    end
  end

  assign bus.o_sw   = sw_r;
  assign bus.o_rise = rise_r;
  assign bus.o_fall = fall_r;
  assign bus.o_busy = busy_r;

`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_WIDTH-1:0] glitch_r;

  // Saturating count of abandoned qualifications.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      glitch_r <= '0;
    end else if (reject_s && (glitch_r != {GLITCH_WIDTH{1'b1}})) begin
      glitch_r <= glitch_r + GLITCH_WIDTH'(1);
    end else begin
      glitch_r <= glitch_r;
    end
  end

  assign bus.o_glitch_cnt = glitch_r;
`endif

endmodule
